// File: rtl/noc_intr_pkt_decoder_pkg.sv
// Shared definitions for the interrupt packet decoder: header layout,
// FSM state encoding and the decoded descriptor.
package noc_intr_pkg;

    localparam int FLIT_W  = 64;
    localparam int DST_X_W = 8;
    localparam int DST_Y_W = 8;
    localparam int FBITS_W = 4;
    localparam int LEN_W   = 8;
    localparam int TYPE_W  = 8;
    localparam int CNT_W   = 16;

    localparam int DST_X_LSB = 42;
    localparam int DST_Y_LSB = 34;
    localparam int FBITS_LSB = 30;
    localparam int LEN_LSB   = 22;
    localparam int TYPE_LSB  = 14;

    // Codes of the surrounding NoC protocol for interrupt messages and L1 fbits.
    localparam logic [TYPE_W-1:0]  MSG_TYPE_INTERRUPT = 8'd60;
    localparam logic [FBITS_W-1:0] NOC_FBITS_L1       = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    typedef struct packed {
        logic [DST_X_W-1:0] dst_x;
        logic [DST_Y_W-1:0] dst_y;
        logic [FBITS_W-1:0] fbits;
        logic [FLIT_W-1:0]  payload;
    } intr_desc_t;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [FLIT_W-1:0] flit);
        return flit[LEN_LSB +: LEN_W];
    endfunction

    function automatic logic [TYPE_W-1:0] hdr_type(input logic [FLIT_W-1:0] flit);
        return flit[TYPE_LSB +: TYPE_W];
    endfunction

endpackage

// File: rtl/noc_intr_pkt_decoder_if.sv
// Flit input stream and descriptor output of the interrupt packet decoder.
// val/rdy: a transfer happens on a rising clk edge where val && rdy; the
// source holds data stable while val is high and rdy low.
interface noc_intr_pkt_decoder_if #(
    parameter int NOC_DATA_WIDTH = 64,
    parameter int X_WIDTH        = 8,
    parameter int Y_WIDTH        = 8
);
    logic                      noc_in_val;
    logic                      noc_in_rdy;
    logic [NOC_DATA_WIDTH-1:0] noc_in_data;

    logic                      intr_val;
    logic                      intr_rdy;
    logic [X_WIDTH-1:0]        intr_dst_x;
    logic [Y_WIDTH-1:0]        intr_dst_y;
    logic [3:0]                intr_fbits;
    logic [NOC_DATA_WIDTH-1:0] intr_payload;

    modport master (
        output noc_in_val, noc_in_data, intr_rdy,
        input  noc_in_rdy, intr_val, intr_dst_x, intr_dst_y, intr_fbits, intr_payload
    );

    modport slave (
        input  noc_in_val, noc_in_data, intr_rdy,
        output noc_in_rdy, intr_val, intr_dst_x, intr_dst_y, intr_fbits, intr_payload
    );
endinterface

// File: rtl/noc_intr_pkt_decoder_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/noc_intr_pkt_decoder.sv
// Reassembles header+payload interrupt packets from the IOB flit stream into
// descriptors; malformed and non-interrupt packets are drained and counted.
module noc_intr_pkt_decoder
    import noc_intr_pkg::*;
#(
    parameter int                 NOC_DATA_WIDTH = FLIT_W,
    parameter int                 X_WIDTH        = DST_X_W,
    parameter int                 Y_WIDTH        = DST_Y_W,
    parameter int                 CNT_WIDTH      = CNT_W,
    parameter logic [TYPE_W-1:0]  INTR_MSG_TYPE  = MSG_TYPE_INTERRUPT
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_intr_pkt_decoder_if.slave bus,
    output logic [CNT_WIDTH-1:0] intr_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt,
    output state_e               dbg_state
);
    state_e            state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    intr_desc_t        desc_q, desc_d;
    logic              intr_inc;
    logic              drop_inc;
    logic [LEN_W-1:0]  hdr_len_w;
    logic [TYPE_W-1:0] hdr_type_w;

    assign hdr_len_w  = hdr_len(bus.noc_in_data);
    assign hdr_type_w = hdr_type(bus.noc_in_data);

    // rdy is high in every state except HOLD, so val alone marks an accept there.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        desc_d   = desc_q;
        intr_inc = 1'b0;
        drop_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.noc_in_val) begin
                    desc_d.dst_x = bus.noc_in_data[DST_X_LSB +: X_WIDTH];
                    desc_d.dst_y = bus.noc_in_data[DST_Y_LSB +: Y_WIDTH];
                    desc_d.fbits = bus.noc_in_data[FBITS_LSB +: FBITS_W];
                    if (hdr_len_w == '0) begin
                        drop_inc = 1'b1;
                    end else if (hdr_type_w == INTR_MSG_TYPE) begin
                        state_d = ST_PAYLOAD;
                        rem_d   = hdr_len_w - 1'b1;
                    end else begin
                        state_d  = ST_DRAIN;
                        rem_d    = hdr_len_w;
                        drop_inc = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (bus.noc_in_val) begin
                    desc_d.payload = bus.noc_in_data;
                    state_d        = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.intr_rdy) begin
                    intr_inc = 1'b1;
                    state_d  = (rem_q != '0) ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (bus.noc_in_val) begin
                    if (rem_q <= LEN_W'(1)) begin
                        rem_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        rem_d = rem_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            desc_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            desc_q  <= desc_d;
        end
    end

    assign bus.noc_in_rdy   = (state_q != ST_HOLD);
    assign bus.intr_val     = (state_q == ST_HOLD);
    assign bus.intr_dst_x   = desc_q.dst_x;
    assign bus.intr_dst_y   = desc_q.dst_y;
    assign bus.intr_fbits   = desc_q.fbits;
    assign bus.intr_payload = desc_q.payload;
    assign dbg_state        = state_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_intr_cnt (
        .clk (clk),
        .clr (rst),
        .inc (intr_inc),
        .cnt (intr_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk (clk),
        .clr (rst),
        .inc (drop_inc),
        .cnt (drop_cnt)
    );
endmodule

// File: doc/noc_intr_pkt_decoder.md
Name: noc_intr_pkt_decoder

Overview:
- Sits directly downstream of the fake-IOB output FIFO. Consumes its 64-bit NoC flit stream (val/rdy) and reassembles header+payload interrupt packets.
- Emits one decoded interrupt descriptor per valid packet on a val/rdy port toward the tile-side interrupt injector / bench monitor.
- Drains and counts malformed or non-interrupt packets, so a stuck or garbled packet can never wedge the IOB FIFO.

Parameters:
- NOC_DATA_WIDTH, 64, flit width.
- X_WIDTH, 8, destination-X field width (header bits [49:42]).
- Y_WIDTH, 8, destination-Y field width (header bits [41:34]).
- CNT_WIDTH, 16, width of the statistics counters.
- INTR_MSG_TYPE, `MSG_TYPE_INTERRUPT, header message type (bits [21:14]) accepted as an interrupt.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- noc_in_val  in  1  flit valid from the IOB FIFO
- noc_in_rdy  out  1  flit accept; a transfer happens when val&&rdy
- noc_in_data  in  NOC_DATA_WIDTH  flit data
- intr_val  out  1  descriptor valid
- intr_rdy  in  1  descriptor accept
- intr_dst_x  out  X_WIDTH  header [49:42]
- intr_dst_y  out  Y_WIDTH  header [41:34]
- intr_fbits  out  4  header [33:30]
- intr_payload  out  NOC_DATA_WIDTH  first payload flit, unmodified
- intr_cnt  out  CNT_WIDTH  descriptors delivered (intr_val&&intr_rdy)
- drop_cnt  out  CNT_WIDTH  packets dropped

Behaviour:
- Clocking/reset: one clock, clk. Synchronous active-high reset rst.
- Reset values: state=IDLE, intr_val=0, all descriptor fields=0, intr_cnt=0, drop_cnt=0, rem=0.
- Reset mid-packet: any partial packet is abandoned and the next flit is treated as a header. No descriptor is emitted.
- Header fields: len = [29:22] (8-bit payload flit count), type = [21:14].
- FSM states: IDLE, PAYLOAD, HOLD, DRAIN.
- noc_in_rdy = 1 in IDLE, PAYLOAD and DRAIN; 0 in HOLD. It is a combinational function of state only and never depends on noc_in_val.
- IDLE, on header accept: latch dst_x, dst_y and fbits.
  - type==INTR_MSG_TYPE and len>=1: go to PAYLOAD, rem=len-1.
  - type!=INTR_MSG_TYPE and len>=1: go to DRAIN, rem=len, drop_cnt+1.
  - len==0 (any type): stay in IDLE, drop_cnt+1.
- PAYLOAD, on accept: latch intr_payload and go to HOLD. intr_val rises the cycle after the payload accept (latency 1).
- HOLD: intr_val=1. All descriptor fields stay stable until intr_rdy. On intr_val&&intr_rdy: intr_cnt+1, intr_val=0 next cycle, then go to DRAIN if rem!=0, else IDLE.
- DRAIN: each accepted flit decrements rem. The accept with rem==1 returns to IDLE. Surplus payload flits of an interrupt packet are discarded without bumping drop_cnt.
- Back-to-back: a header may be accepted the cycle after HOLD exits to IDLE. Best-case packet rate is one descriptor per 3 cycles for len=1.
- Counters saturate at all-ones; no wrap.
- Flit ordering is preserved; the block never reorders or duplicates.
- Simultaneous events: in IDLE, a dropped header and its drop_cnt increment occur in the same cycle.

Decomposition:
- Shared package noc_intr_pkg:
  - header field bit positions (DST_X, DST_Y, FBITS, LEN, TYPE);
  - state encoding typedef;
  - descriptor struct {dst_x, dst_y, fbits, payload}.
- One natural sub-module: sat_counter (parameterised width, inc, synchronous clear), instantiated for intr_cnt and drop_cnt.

Test Plan:
- T1, single packet:
  - Stimulus: header type=INTR, len=1, x=2, y=1, fbits=`NOC_FBITS_L1, then payload 64'h0000_1234_5678_0105, intr_rdy=1.
  - Response: intr_val high exactly 1 cycle after the payload accept, with dst_x=2, dst_y=1 and payload matching bit-exact; intr_cnt=1.
- T2, backpressure:
  - Stimulus: as T1 with intr_rdy=0 for 5 cycles, and a second packet offered meanwhile.
  - Response: noc_in_rdy=0 throughout HOLD; descriptor fields stable; second packet decoded correctly after release; intr_cnt=2.
- T3, non-interrupt type:
  - Stimulus: header type=8'h0B, len=3, plus 3 flits, followed by a valid interrupt packet.
  - Response: no intr_val for the first packet; drop_cnt=1; second packet delivered.
- T4, length edge cases:
  - Stimulus: len=0 interrupt header, then an interrupt with len=4.
  - Response: drop_cnt=1; one descriptor carrying payload flit 0; flits 1-3 drained; returns to IDLE; drop_cnt stays 1.
- T5, reset mid-packet:
  - Stimulus: assert rst for 1 cycle after a header accept (state PAYLOAD), then send a full packet.
  - Response: all outputs at reset values; the next flit is parsed as a header; exactly one descriptor delivered.
- T6, saturation:
  - Stimulus: force drop_cnt to 16'hFFFE, then send 3 len=0 headers.
  - Response: drop_cnt=16'hFFFF and holds; noc_in_rdy stays 1 throughout.
